// File: rtl/aib_word_seq.sv
// Byte-serial sequencer for the shared AES inverse S-box ISE unit.
// Optional abort input enabled by defining AIB_WORD_SEQ_ABORT_EN.
module aib_word_seq #(
   parameter int NBYTES = 4,
   parameter int IDXW   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef AIB_WORD_SEQ_ABORT_EN
   input  logic                  abort,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_word,
   output logic [7:0]            sbox_a,
   input  logic [7:0]            sbox_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_word,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   state_t              state;
   state_t              state_n;
   logic [IDXW-1:0]     idx;
   logic [IDXW+2:0]     lane_lo;
   logic [8*NBYTES-1:0] data;
   logic                last;
   logic                abort_i;

`ifdef AIB_WORD_SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign lane_lo  = {idx, 3'b000};
   assign last     = (idx == LAST);
   assign out_word = data;

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      sbox_a    = 8'h00;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_n = SUB;
         end
         SUB: begin
            busy   = 1'b1;
            sbox_a = data[lane_lo +: 8];
            if (abort_i)
               state_n = IDLE;
            else if (last)
               state_n = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (abort_i || out_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         data  <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  data <= in_word;
                  idx  <= '0;
               end
            end
            SUB: begin
               // abort leaves data as-is; only the index is discarded
               if (abort_i) begin
                  idx <= '0;
               end else begin
                  data[lane_lo +: 8] <= sbox_result;
                  idx <= last ? '0 : idx + 1'b1;
               end
            end
            DONE: begin
               if (abort_i)
                  idx <= '0;
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_aib_word_seq.sv
// Directed bench for aib_word_seq with a behavioural inverse S-box.
// Abort cases run when AIB_WORD_SEQ_ABORT_EN is defined.
module tb_aib_word_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic [7:0]  sbox_a;
   logic [7:0]  sbox_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic        busy;
`ifdef AIB_WORD_SEQ_ABORT_EN
   logic        abort;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   aib_word_seq #(.NBYTES(4), .IDXW(4)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef AIB_WORD_SEQ_ABORT_EN
      .abort       (abort),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word     (in_word),
      .sbox_a      (sbox_a),
      .sbox_result (sbox_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .busy        (busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // inverse affine map followed by GF(2^8) inversion
   function automatic logic [7:0] inv_sbox(input logic [7:0] v);
      logic [7:0] b;
      logic [7:0] r = 8'h00;
      b = {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
      for (int i = 1; i < 256; i++)
         if (gmul(b, 8'(i)) == 8'h01) r = 8'(i);
      return r;
   endfunction

   always_comb sbox_result = inv_sbox(sbox_a);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] w;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic run_word(input logic [31:0] w, input logic [31:0] exp);
      logic [31:0] t;
      t = w;
      check("in_ready_pre", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_word  = w;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sbox_a_lane%0d", k), 32'(sbox_a), 32'(t[7:0]));
         check("busy_sub", {30'd0, busy, in_ready}, 32'd2);
         t = t >> 8;
         tick();
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_word", out_word, exp);
      tick();
      check("idle_after", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      vecs[0] = '{w: 32'h00010203, exp: 32'h52096AD5};
      vecs[1] = '{w: 32'h63636363, exp: 32'h00000000};
      vecs[2] = '{w: 32'hFFFFFFFF, exp: 32'h7D7D7D7D};
      vecs[3] = '{w: 32'h04050607, exp: 32'h3036A538};
      vecs[4] = '{w: 32'h08090A0B, exp: 32'hBF40A39E};
      vecs[5] = '{w: 32'h0C0D0E0F, exp: 32'h81F3D7FB};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b1;
`ifdef AIB_WORD_SEQ_ABORT_EN
      abort     = 1'b0;
`endif
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sbox_a", 32'(sbox_a), 32'd0);
      check("rst_out_word", out_word, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++)
         run_word(vecs[i].w, vecs[i].exp);

      // backpressure, with a competing word offered meanwhile
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_word   = 32'h00010203;
      tick();
      in_word   = 32'hFFFFFFFF;
      repeat (4) tick();
      for (int c = 0; c < 10; c++) begin
         check("bp_hold", {out_valid, in_ready, busy}, {1'b1, 1'b0, 1'b1});
         check("bp_word", out_word, 32'h52096AD5);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_release_word", out_word, 32'h52096AD5);
      tick();
      check("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
      tick();
      check("bp_single", {30'd0, in_ready, out_valid}, 32'd2);

      // reset two cycles into SUB
      in_valid = 1'b1;
      in_word  = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
      check("mid_rst_sbox_a", 32'(sbox_a), 32'd0);
      run_word(32'h0C0D0E0F, 32'h81F3D7FB);

      // back-to-back with in_valid held high
      in_valid = 1'b1;
      in_word  = 32'h00010203;
      tick();
      in_word  = 32'h08090A0B;
      repeat (4) tick();
      check("b2b_first", out_word, 32'h52096AD5);
      check("b2b_first_valid", 32'(out_valid), 32'd1);
      tick();
      check("b2b_gap", {30'd0, in_ready, out_valid}, 32'd2);
      tick();
      check("b2b_second_acc", {30'd0, busy, in_ready}, 32'd2);
      check("b2b_second_lane0", 32'(sbox_a), 32'h0B);
      in_valid = 1'b0;
      repeat (4) tick();
      check("b2b_second", out_word, 32'hBF40A39E);
      check("b2b_second_valid", 32'(out_valid), 32'd1);
      tick();

`ifdef AIB_WORD_SEQ_ABORT_EN
      in_valid = 1'b1;
      in_word  = 32'h63636363;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
      repeat (5) tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_word  = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0;
      abort = 1'b1;
      rst   = 1'b1;
      tick();
      abort = 1'b0;
      rst   = 1'b0;
      check("abort_rst", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
      check("abort_rst_word", out_word, 32'd0);
      abort = 1'b1;
      in_valid = 1'b1;
      in_word  = 32'h00010203;
      tick();
      abort = 1'b0;
      in_valid = 1'b0;
      check("abort_idle_accept", {30'd0, busy, in_ready}, 32'd2);
      repeat (4) tick();
      check("abort_idle_word", out_word, 32'h52096AD5);
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
